rf_op_sequencer: RTL and testbench

- Sequencer and 2-way arbiter in front of the 4x1-bit register file: two write data-ports in, one shared write port, two read ports.
- Two requesters submit 1-bit ALU commands. The block grants one requester round-robin, drives both read selects, and captures the operands.
- It then computes the result, drives the write port for one cycle, and returns the result with an ack.
- Sits between the control logic and the register file: it owns upr_1, upr_2, upr_in, data and WE exclusively.

---
 rtl/rf_seq_pkg.sv | 49 ++++
 rtl/rf_rr_arb2.sv | 49 ++++
 rtl/rf_op_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_rf_op_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_seq_pkg.sv
// rf_seq_pkg: shared types, command field layout and the 1-bit ALU used by
// the register-file operation sequencer.
package rf_seq_pkg;

  // Command word layout: {op[8:6], dst[5:4], src2[3:2], src1[1:0]}
  localparam int CMD_W      = 9;
  localparam int SEL_W      = 2;
  localparam int OP_FIELD_W = 3;
  localparam int SRC1_LSB   = 0;
  localparam int SRC2_LSB   = 2;
  localparam int DST_LSB    = 4;
  localparam int OP_LSB     = 6;

  typedef enum logic [2:0] {
    OP_MOV  = 3'b000,
    OP_AND  = 3'b001,
    OP_OR   = 3'b010,
    OP_XOR  = 3'b011,
    OP_NOT  = 3'b100,
    OP_SET0 = 3'b101,
    OP_SET1 = 3'b110,
    OP_RD   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    ACK   = 2'b11
  } state_e;

  // Result of one command given operand a (read port 1) and b (read port 2)
  function automatic logic alu_eval(input op_e op, input logic a, input logic b);
    logic r_s;
    case (op)
      OP_MOV:  r_s = a;
      OP_AND:  r_s = a & b;
      OP_OR:   r_s = a | b;
      OP_XOR:  r_s = a ^ b;
      OP_NOT:  r_s = ~a;
      OP_SET0: r_s = 1'b0;
      OP_SET1: r_s = 1'b1;
      OP_RD:   r_s = a;
      default: r_s = 1'b0;
    endcase
    return r_s;
  endfunction

endpackage

// File: rtl/rf_rr_arb2.sv
// rf_rr_arb2: two-way round-robin arbiter. The grant is combinational from
// the request vector and the held priority; priority moves to the loser
// whenever a grant is taken (advance high with at least one request).
module rf_rr_arb2 #(
  parameter int START_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       gid
);

  logic prio_r;
  logic gid_s;

  // Pick the winner: the favoured requester on contention, else whoever asks
  always_comb begin
    gid_s = 1'b0;
    gnt   = 2'b00;
    if (req == 2'b11) begin
      gid_s = prio_r;
    end else if (req[1]) begin
      gid_s = 1'b1;
    end else begin
      gid_s = 1'b0;
    end
    if (req != 2'b00) begin
      gnt = gid_s ? 2'b10 : 2'b01;
    end else begin
      gnt = 2'b00;
    end
  end

  assign gid = gid_s;

  // Priority register: after any taken grant the other requester is favoured
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_r <= (START_PRIO != 0) ? 1'b1 : 1'b0;
    end else if (advance && (req != 2'b00)) begin
      prio_r <= ~gid_s;
    end else begin
      prio_r <= prio_r;
    end
  end

endmodule

// File: rtl/rf_op_sequencer.sv
// rf_op_sequencer: arbitrates two requesters of 1-bit ALU commands, reads the
// operands from a 4x1 register file, writes the result back and acks.
// Optional feature macro: RF_SEQ_OPCNT_EN adds op_cnt, a saturating count of
// acked commands.
module rf_op_sequencer
  import rf_seq_pkg::*;
#(
  parameter int ADDR_W     = 2,
  parameter int OP_W       = 3,
  parameter int START_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_0,
  input  logic [CMD_W-1:0]  cmd_0,
  output logic              ack_0,
  input  logic              req_1,
  input  logic [CMD_W-1:0]  cmd_1,
  output logic              ack_1,
  output logic              res,
  output logic              busy,
  output logic [ADDR_W-1:0] rf_upr_1,
  output logic [ADDR_W-1:0] rf_upr_2,
  input  logic              rf_out_1,
  input  logic              rf_out_2,
  output logic [ADDR_W-1:0] rf_upr_in,
  output logic              rf_data,
`ifdef RF_SEQ_OPCNT_EN
  output logic [7:0]        op_cnt,
`endif
  output logic              rf_we
);

  state_e              state_r;
  state_e              state_next_s;

  logic [1:0]          gnt_s;
  logic                gid_s;
  logic                advance_s;
  logic [CMD_W-1:0]    cmd_gnt_s;
  logic [OP_W-1:0]     op_bits_s;

  op_e                 op_r;
  logic [ADDR_W-1:0]   dst_r;
  logic                gid_r;
  logic                a_r;
  logic                b_r;

  logic [ADDR_W-1:0]   upr_1_next_s;
  logic [ADDR_W-1:0]   upr_2_next_s;
  logic [ADDR_W-1:0]   upr_in_next_s;
  logic                data_next_s;
  logic                we_next_s;
  logic [1:0]          ack_next_s;
  logic                res_next_s;
  logic                busy_next_s;

  logic [ADDR_W-1:0]   upr_1_r;
  logic [ADDR_W-1:0]   upr_2_r;
  logic [ADDR_W-1:0]   upr_in_r;
  logic                data_r;
  logic                we_r;
  logic [1:0]          ack_r;
  logic                res_r;
  logic                busy_r;

  assign advance_s = (state_r == IDLE);
  assign cmd_gnt_s = gid_s ? cmd_1 : cmd_0;
  assign op_bits_s = cmd_gnt_s[OP_LSB +: OP_W];

  rf_rr_arb2 #(
    .START_PRIO (START_PRIO)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({req_1, req_0}),
    .advance (advance_s),
    .gnt     (gnt_s),
    .gid     (gid_s)
  );

  // Next state plus next value of every registered output
  always_comb begin
    state_next_s  = state_r;
    upr_1_next_s  = '0;
    upr_2_next_s  = '0;
    upr_in_next_s = '0;
    data_next_s   = 1'b0;
    we_next_s     = 1'b0;
    ack_next_s    = 2'b00;
    res_next_s    = res_r;
    case (state_r)
      IDLE: begin
        if (gnt_s != 2'b00) begin
          state_next_s = READ;
          upr_1_next_s = cmd_gnt_s[SRC1_LSB +: ADDR_W];
          upr_2_next_s = cmd_gnt_s[SRC2_LSB +: ADDR_W];
        end else begin
          state_next_s = IDLE;
        end
      end
      READ: begin
        if (op_r == OP_RD) begin
          state_next_s = ACK;
          ack_next_s   = gid_r ? 2'b10 : 2'b01;
          res_next_s   = alu_eval(op_r, rf_out_1, rf_out_2);
        end else begin
          state_next_s  = WRITE;
          upr_in_next_s = dst_r;
          data_next_s   = alu_eval(op_r, rf_out_1, rf_out_2);
          we_next_s     = 1'b1;
        end
      end
      WRITE: begin
        state_next_s = ACK;
        ack_next_s   = gid_r ? 2'b10 : 2'b01;
        res_next_s   = alu_eval(op_r, a_r, b_r);
      end
      ACK: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
    busy_next_s = (state_next_s != IDLE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Latch the granted command's opcode, destination and requester id
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r  <= OP_MOV;
      dst_r <= '0;
      gid_r <= 1'b0;
    end else if ((state_r == IDLE) && (gnt_s != 2'b00)) begin
      op_r  <= op_e'(op_bits_s);
      dst_r <= cmd_gnt_s[DST_LSB +: ADDR_W];
      gid_r <= gid_s;
    end else begin
      op_r  <= op_r;
      dst_r <= dst_r;
      gid_r <= gid_r;
    end
  end

  // Capture both read-port operands at the end of the READ cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= 1'b0;
      b_r <= 1'b0;
    end else if (state_r == READ) begin
      a_r <= rf_out_1;
      b_r <= rf_out_2;
    end else begin
      a_r <= a_r;
      b_r <= b_r;
    end
  end

  // Output registers, loaded with the values belonging to the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      upr_1_r  <= '0;
      upr_2_r  <= '0;
      upr_in_r <= '0;
      data_r   <= 1'b0;
      we_r     <= 1'b0;
      ack_r    <= 2'b00;
      res_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      upr_1_r  <= upr_1_next_s;
      upr_2_r  <= upr_2_next_s;
      upr_in_r <= upr_in_next_s;
      data_r   <= data_next_s;
      we_r     <= we_next_s;
      ack_r    <= ack_next_s;
      res_r    <= res_next_s;
      busy_r   <= busy_next_s;
    end
  end

  assign rf_upr_1  = upr_1_r;
  assign rf_upr_2  = upr_2_r;
  assign rf_upr_in = upr_in_r;
  assign rf_data   = data_r;
  // A reset arriving during WRITE must kill the write in that same cycle
  assign rf_we     = we_r & ~rst;
  assign ack_0     = ack_r[0];
  assign ack_1     = ack_r[1];
  assign res       = res_r;
  assign busy      = busy_r;

`ifdef RF_SEQ_OPCNT_EN
  logic [7:0] op_cnt_r;

  // Saturating count of acked commands
  always_ff @(posedge clk) begin
    if (rst) begin
      op_cnt_r <= 8'd0;
    end else if ((state_r == ACK) && (op_cnt_r != 8'hFF)) begin
      op_cnt_r <= op_cnt_r + 8'd1;
    end else begin
      op_cnt_r <= op_cnt_r;
    end
  end

  assign op_cnt = op_cnt_r;
`endif

endmodule

// File: tb/tb_rf_op_sequencer.sv
// tb_rf_op_sequencer: directed and randomized commands from two requesters,
// checked against a transaction-level model of the register file, the
// round-robin rule and the command latencies.
module tb_rf_op_sequencer;

  localparam int START_PRIO = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_0, req_1;
  logic [8:0] cmd_0, cmd_1;
  logic       ack_0, ack_1, res, busy;
  logic [1:0] rf_upr_1, rf_upr_2, rf_upr_in;
  logic       rf_out_1, rf_out_2, rf_data, rf_we;
`ifdef RF_SEQ_OPCNT_EN
  logic [7:0] op_cnt;
`endif

  // Environment register file (not part of the reference model)
  logic rf_mem [4];
  logic rf_clr;

  // Reference model state
  logic       mdl_rf [4];
  int         mdl_prio;
  int         mdl_acks;
  bit         pend [2];
  logic [8:0] pcmd [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rf_op_sequencer #(
    .ADDR_W     (2),
    .OP_W       (3),
    .START_PRIO (START_PRIO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_0     (req_0),
    .cmd_0     (cmd_0),
    .ack_0     (ack_0),
    .req_1     (req_1),
    .cmd_1     (cmd_1),
    .ack_1     (ack_1),
    .res       (res),
    .busy      (busy),
    .rf_upr_1  (rf_upr_1),
    .rf_upr_2  (rf_upr_2),
    .rf_out_1  (rf_out_1),
    .rf_out_2  (rf_out_2),
    .rf_upr_in (rf_upr_in),
    .rf_data   (rf_data),
`ifdef RF_SEQ_OPCNT_EN
    .op_cnt    (op_cnt),
`endif
    .rf_we     (rf_we)
  );

  assign rf_out_1 = rf_mem[rf_upr_1];
  assign rf_out_2 = rf_mem[rf_upr_2];

  // Register file: clear on bench request, otherwise write when enabled
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 4; i++) rf_mem[i] <= 1'b0;
    end else if (rf_we) begin
      rf_mem[rf_upr_in] <= rf_data;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic ref_alu(input int op, input logic a, input logic b);
    case (op)
      0: return a;
      1: return a & b;
      2: return a | b;
      3: return a ^ b;
      4: return ~a;
      5: return 1'b0;
      6: return 1'b1;
      default: return a;
    endcase
  endfunction

  function automatic logic [8:0] mk_cmd(input int op, input int dst, input int s2, input int s1);
    logic [2:0] o = 3'(op);
    logic [1:0] d = 2'(dst);
    logic [1:0] b = 2'(s2);
    logic [1:0] a = 2'(s1);
    return {o, d, b, a};
  endfunction

  // One arbitration slot, entered and left at the negedge of an IDLE cycle.
  // rst_at > 0 asserts rst in that cycle of the command (2 = WRITE).
  task automatic run_slot(input bit new0, input logic [8:0] c0,
                          input bit new1, input logic [8:0] c1, input int rst_at);
    int w, op, dst, s1, s2, lat, we_seen;
    logic r;
    logic [8:0] wc;
    if (!pend[0] && new0) begin pend[0] = 1'b1; pcmd[0] = c0; end
    if (!pend[1] && new1) begin pend[1] = 1'b1; pcmd[1] = c1; end
    req_0 = pend[0]; cmd_0 = pcmd[0];
    req_1 = pend[1]; cmd_1 = pcmd[1];
    if (!pend[0] && !pend[1]) begin
      @(posedge clk); @(negedge clk); #1;
      check_val("idle_busy", 32'(busy), 32'd0);
      return;
    end
    if (pend[0] && pend[1]) w = mdl_prio;
    else w = pend[1] ? 1 : 0;
    mdl_prio = 1 - w;
    wc  = pcmd[w];
    op  = int'(wc[8:6]);
    dst = int'(wc[5:4]);
    s2  = int'(wc[3:2]);
    s1  = int'(wc[1:0]);
    r   = ref_alu(op, mdl_rf[s1], mdl_rf[s2]);
    lat = (op == 7) ? 2 : 3;
    we_seen = 0;
    @(posedge clk);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == rst_at) rst = 1'b1;
      #1;
      if (k == rst_at) begin
        check_val("rst_we", 32'(rf_we), 32'd0);
        check_val("rst_ack", 32'({ack_1, ack_0}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_res", 32'(res), 32'd0);
        check_val("rst_ack2", 32'({ack_1, ack_0}), 32'd0);
        pend[w]  = 1'b0;
        mdl_prio = START_PRIO;
        mdl_acks = 0;
        req_0 = pend[0];
        req_1 = pend[1];
        return;
      end
      if (rf_we) we_seen++;
      check_val("busy", 32'(busy), 32'd1);
      if (k == 1) begin
        check_val("rd_sel1", 32'(rf_upr_1), 32'(s1));
        check_val("rd_sel2", 32'(rf_upr_2), 32'(s2));
      end
      if (k == 2 && lat == 3) begin
        check_val("wr_sel", 32'(rf_upr_in), 32'(dst));
        check_val("wr_data", 32'(rf_data), 32'(r));
      end
      if (k < lat) begin
        check_val("early_ack", 32'({ack_1, ack_0}), 32'd0);
      end else begin
        check_val("ack_vec", 32'({ack_1, ack_0}), (w == 1) ? 32'd2 : 32'd1);
        check_val("res", 32'(res), 32'(r));
      end
    end
    check_val("we_count", 32'(we_seen), (op == 7) ? 32'd0 : 32'd1);
    if (op != 7) mdl_rf[dst] = r;
    pend[w] = 1'b0;
    mdl_acks++;
    @(posedge clk); @(negedge clk); #1;
    check_val("post_busy", 32'(busy), 32'd0);
    check_val("post_ack", 32'({ack_1, ack_0}), 32'd0);
    check_val("res_hold", 32'(res), 32'(r));
    for (int i = 0; i < 4; i++) check_val("rf_state", 32'(rf_mem[i]), 32'(mdl_rf[i]));
`ifdef RF_SEQ_OPCNT_EN
    check_val("op_cnt", 32'(op_cnt), (mdl_acks > 255) ? 32'd255 : 32'(mdl_acks));
`endif
  endtask

  initial begin
    rst = 1'b1; rf_clr = 1'b1;
    req_0 = 1'b0; req_1 = 1'b0; cmd_0 = 9'd0; cmd_1 = 9'd0;
    for (int i = 0; i < 4; i++) mdl_rf[i] = 1'b0;
    mdl_prio = START_PRIO; mdl_acks = 0;
    pend[0] = 1'b0; pend[1] = 1'b0; pcmd[0] = 9'd0; pcmd[1] = 9'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_val("reset_ack", 32'({ack_1, ack_0}), 32'd0);
    check_val("reset_res", 32'(res), 32'd0);
    check_val("reset_busy", 32'(busy), 32'd0);
    check_val("reset_we", 32'(rf_we), 32'd0);
    check_val("reset_sel", 32'({rf_upr_1, rf_upr_2, rf_upr_in}), 32'd0);
    rst = 1'b0; rf_clr = 1'b0;
    @(negedge clk); #1;

    // SET1 r2 then RD r2
    run_slot(1'b1, mk_cmd(6, 2, 0, 0), 1'b0, 9'd0, 0);
    run_slot(1'b1, mk_cmd(7, 0, 0, 2), 1'b0, 9'd0, 0);
    // r0=1, r1=0, XOR r3, RD r3, AND r3
    run_slot(1'b1, mk_cmd(6, 0, 0, 0), 1'b0, 9'd0, 0);
    run_slot(1'b0, 9'd0, 1'b1, mk_cmd(5, 1, 0, 0), 0);
    run_slot(1'b1, mk_cmd(3, 3, 1, 0), 1'b0, 9'd0, 0);
    run_slot(1'b1, mk_cmd(7, 0, 0, 3), 1'b0, 9'd0, 0);
    run_slot(1'b1, mk_cmd(1, 3, 1, 0), 1'b0, 9'd0, 0);
    // Back-to-back MOVs through r1 into r2
    run_slot(1'b1, mk_cmd(0, 1, 0, 0), 1'b0, 9'd0, 0);
    run_slot(1'b1, mk_cmd(0, 2, 0, 1), 1'b0, 9'd0, 0);
    // Both requesters always pending: grants must alternate
    for (int i = 0; i < 6; i++) begin
      run_slot(1'b1, mk_cmd(4, i % 4, 0, (i + 1) % 4), 1'b1, mk_cmd(2, (i + 2) % 4, 1, 3), 0);
    end
    // Drain any leftover request
    run_slot(1'b0, 9'd0, 1'b0, 9'd0, 0);
    run_slot(1'b0, 9'd0, 1'b0, 9'd0, 0);
    // Reset during WRITE of SET1 r0 (r0 cleared first)
    run_slot(1'b1, mk_cmd(5, 0, 0, 0), 1'b0, 9'd0, 0);
    run_slot(1'b1, mk_cmd(6, 0, 0, 0), 1'b0, 9'd0, 2);
    run_slot(1'b1, mk_cmd(7, 0, 0, 0), 1'b0, 9'd0, 0);

    // Randomized traffic
    for (int i = 0; i < 320; i++) begin
      run_slot(($urandom_range(0, 3) != 0), 9'($urandom_range(0, 511)),
               ($urandom_range(0, 3) != 0), 9'($urandom_range(0, 511)), 0);
    end

`ifdef RF_SEQ_OPCNT_EN
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("op_cnt_rst", 32'(op_cnt), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
